// File: rtl/tensor_fma_seq.sv
// Issue-side sequencer for a combinational 4-lane BF16 tensor unit: runs one FMA per operand beat, then an optional ReLU.
// Optional feature macro TENSOR_FMA_SEQ_INIT_EN adds cmd_init so the accumulator can be seeded for chained partial sums.
module tensor_fma_seq #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_relu,
`ifdef TENSOR_FMA_SEQ_INIT_EN
  input  logic [63:0]      cmd_init,
`endif
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [63:0]      op_a,
  input  logic [63:0]      op_b,
  output logic             ts_en,
  output logic [1:0]       ts_op,
  output logic [63:0]      ts_a,
  output logic [63:0]      ts_b,
  output logic [63:0]      ts_c,
  input  logic [63:0]      ts_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data
);

  localparam int unsigned DATA_W = 64;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] RELU  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_FMA  = 2'b01;
  localparam logic [1:0] OP_RELU = 2'b10;

  logic [1:0]        state, state_d;
  logic [DATA_W-1:0] acc, acc_d;
  logic [LEN_W-1:0]  cnt, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              relu_q, relu_d;
  logic [DATA_W-1:0] acc_seed;
  logic              last_beat;

  // Accumulator seed applied on job accept
`ifdef TENSOR_FMA_SEQ_INIT_EN
  assign acc_seed = cmd_init;
`else
  assign acc_seed = '0;
`endif

  assign last_beat = (cnt == LEN_W'(len_q - LEN_W'(1)));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      relu_q <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      len_q  <= len_d;
      relu_q <= relu_d;
    end
  end

  // Next-state, register updates and tensor-unit issue (tensor unit answers in the same cycle)
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    len_d   = len_q;
    relu_d  = relu_q;
    ts_en   = 1'b0;
    ts_op   = OP_MUL;
    ts_a    = '0;
    ts_b    = '0;
    ts_c    = '0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          len_d  = cmd_len;
          relu_d = cmd_relu;
          acc_d  = acc_seed;
          cnt_d  = '0;
          if (cmd_len == '0) begin
            state_d = cmd_relu ? RELU : DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        ts_en = op_valid;
        ts_op = OP_FMA;
        ts_a  = op_a;
        ts_b  = op_b;
        ts_c  = acc;
        if (op_valid) begin
          acc_d = ts_out;
          cnt_d = cnt + LEN_W'(1);
          if (last_beat) begin
            state_d = relu_q ? RELU : DONE;
          end
        end
      end

      RELU: begin
        ts_en   = 1'b1;
        ts_op   = OP_RELU;
        ts_a    = acc;
        acc_d   = ts_out;
        state_d = DONE;
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      op_ready  <= (state_d == ACCUM);
      res_valid <= (state_d == DONE);
    end
  end

  assign res_data = acc;

endmodule

// File: doc/tensor_fma_seq.md
Name: tensor_fma_seq

Overview:
- Issue-side sequencer for the combinational 4-lane BF16 tensor datapath (ops MUL/FMA/RELU).
- Accepts a dot-product job: a length plus a stream of 64-bit {a,b} operand beats. It issues one FMA per beat with c fed from its own accumulator register.
- Optionally applies a final ReLU, then returns the 64-bit packed result through a valid/ready handshake.
- Sits between the warp issue/register-read stage and the tensor unit. It drives tensor_en/tensor_op/a/b/c and consumes the tensor unit's out.

Parameters:
- LEN_W, 8, width of job length. Max beats per job = 2^LEN_W-1.

Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- cmd_valid  input  1  job request
- cmd_ready  output  1  sequencer can accept job
- cmd_len  input  LEN_W  number of operand beats; 0 allowed
- cmd_relu  input  1  apply ReLU after accumulation
- op_valid  input  1  operand beat valid
- op_ready  output  1  sequencer accepts operand beat
- op_a  input  64  four BF16 lanes, lane0 = [15:0]
- op_b  input  64  four BF16 lanes
- ts_en  output  1  to tensor_en
- ts_op  output  2  to tensor_op: 00 MUL, 01 FMA, 10 RELU
- ts_a  output  64  to tensor a
- ts_b  output  64  to tensor b
- ts_c  output  64  to tensor c
- ts_out  input  64  from tensor out (combinational, same cycle)
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_data  output  64  packed accumulator

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, acc=0, cnt=0, len/relu regs=0.
  - Resulting outputs: cmd_ready=1, op_ready=0, res_valid=0, res_data=0, ts_en=0, ts_op=00, ts_a/b/c=0.
- Default drive: outside ACCUM/RELU issue cycles, ts_en=0, ts_op=00, ts_a=ts_b=ts_c=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch len and relu, acc<=0 (BF16 +0 in all lanes), cnt<=0.
  - Next state: len==0 -> (relu ? RELU : DONE); else ACCUM.
- ACCUM:
  - op_ready=1; cmd_ready=0.
  - Each cycle, combinationally: ts_en=op_valid, ts_op=01, ts_a=op_a, ts_b=op_b, ts_c=acc.
  - On op_valid: acc<=ts_out and cnt<=cnt+1.
  - When cnt==len-1 with op_valid: next state = relu ? RELU : DONE. Otherwise stay.
  - op_valid low: no issue, acc and cnt hold (stall, no bubble penalty beyond the idle cycle).
- RELU (one cycle):
  - ts_en=1, ts_op=10, ts_a=acc, ts_b=ts_c=0.
  - acc<=ts_out; next DONE.
- DONE:
  - res_valid=1, res_data=acc.
  - res_ready high -> IDLE. Low -> hold res_valid and res_data stable.
  - res_data=acc in all states. Consumers sample it only with res_valid.
- Throughput and latency:
  - One beat per clock; the tensor unit is combinational, so there is no internal pipeline.
  - Latency from last beat accepted to res_valid: 1 cycle, or 2 with ReLU.
  - len==0: res_valid is asserted the cycle after cmd accept, or 2 cycles after with ReLU.
- Arithmetic: all lane arithmetic is delegated to the tensor unit. The sequencer never modifies lane data; it only packs/unpacks 64-bit words.
- Ignored inputs:
  - cmd_valid is ignored outside IDLE.
  - op_valid is ignored outside ACCUM. No acceptance occurs and op_ready stays 0.
- Counter: cnt is LEN_W bits and never wraps, because the job ends at len-1.
- Reset mid-job: asynchronous return to reset state. The partial accumulator is discarded and no res_valid is produced.

Optional Feature:
- Macro: TENSOR_FMA_SEQ_INIT_EN.
- Defined: adds input port cmd_init [63:0]. On cmd accept, acc<=cmd_init instead of 0, allowing chained partial sums (e.g. K-split GEMM).
- Undefined: port absent; acc always starts at 0.

Test Plan:
- len=2, relu=0; beats a=0x3F80 (1.0) x4 lanes, b=0x4000 (2.0) x4 lanes, both beats -> res_data=64'h4080_4080_4080_4080 (4.0). res_valid 1 cycle after 2nd beat; ts_op=01 and ts_c=0 on 1st beat, ts_c=0x4000 lanes on 2nd beat.
- len=1, relu=1; a={0xBF80,0x3F80,0xBF80,0x3F80}, b=0x4000 all lanes -> FMA gives {C000,4000,C000,4000}. The RELU cycle shows ts_op=10. Final res_data=64'h0000_4000_0000_4000.
- len=0, relu=0 -> res_valid the cycle after cmd accept, res_data=0. op_ready never asserted.
- Backpressure: len=3, op_valid toggled 1-0-0-1-1 -> exactly 3 FMAs, acc unchanged on stall cycles. With res_ready held low 5 cycles, res_valid/res_data stay stable and cmd_ready=0 until handshake.
- Reset mid-ACCUM: assert rst_n=0 after 1 of 4 beats -> all outputs at reset values immediately (async). A new len=1 job afterwards yields only the new product.
- With TENSOR_FMA_SEQ_INIT_EN: cmd_init=0x3F80 lanes, len=1, a=b=0x3F80 -> res_data=64'h4000_4000_4000_4000 (2.0).
